// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Round-robin arbiter and sequencer that shares one combinational
//   single-precision multiplier among NUM_REQ requesters. The arbiter takes an
//   operand pair from one requester and registers it onto mul_x/mul_y. It then
//   captures mul_z one cycle later and returns the product with the owning
//   requester index on a valid/ready response channel.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   req_valid/req_ready per-requester handshake (at most one ready bit set)
//   req_x, req_y        packed operands, requester i at [32*i +: 32]
//   mul_x, mul_y        registered operands to the shared multiplier
//   mul_z               multiplier product (combinational from mul_x/mul_y)
//   resp_valid/ready    response handshake
//   resp_z, resp_id     registered product and owning requester index
//   op_count            completed responses, wraps modulo 2^CNT_W
//
// Build option
//   FP_MUL_ARB_ZERO_SKIP_EN : an operand with a zero exponent field bypasses
//   the multiplier. The response becomes +0 after a single cycle, and
//   mul_x/mul_y are left untouched.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_x,
  input  logic [32*NUM_REQ-1:0]  req_y,
  output logic [31:0]            mul_x,
  output logic [31:0]            mul_y,
  input  logic [31:0]            mul_z,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_z,
  output logic [ID_W-1:0]        resp_id,
  output logic [CNT_W-1:0]       op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_reg;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              accept_en;
  logic              accept;
  logic              zero_op;
  logic [31:0]       sel_x, sel_y;
  int unsigned       scan_idx;

  // Priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = 32'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(scan_idx);
      end
    end
  end

  assign sel_x = req_x[32*grant_id +: 32];
  assign sel_y = req_y[32*grant_id +: 32];

`ifdef FP_MUL_ARB_ZERO_SKIP_EN
  assign zero_op = (sel_x[30:23] == 8'h00) || (sel_y[30:23] == 8'h00);
`else
  assign zero_op = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_op ? RESP : CALC;
      CALC: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          if (accept) state_nxt = zero_op ? RESP : CALC;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. rst_n gates the accept path so that no ready is shown while
  // reset is held, even though the state is already IDLE.
  always_comb begin
    accept_en  = rst_n && ((state == IDLE) || ((state == RESP) && resp_ready));
    accept     = accept_en && grant_any;
    resp_valid = (state == RESP);
    req_ready  = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Datapath. accept and CALC never coincide, so the resp_z/resp_id writes
  // below are mutually exclusive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      id_reg   <= '0;
      mul_x    <= '0;
      mul_y    <= '0;
      resp_z   <= '0;
      resp_id  <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        if (zero_op) begin
          resp_z  <= '0;
          resp_id <= grant_id;
        end else begin
          mul_x  <= sel_x;
          mul_y  <= sel_y;
          id_reg <= grant_id;
        end
      end
      if (state == CALC) begin
        resp_z  <= mul_z;
        resp_id <= id_reg;
      end
      if ((state == RESP) && resp_ready) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter: bench-side multiplier model on mul_z,
// scoreboard of expected responses pushed at accept, popped at completion.
module tb_fp_mul_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 16;
`ifdef FP_MUL_ARB_ZERO_SKIP_EN
  localparam int unsigned ZERO_LAT = 1;
`else
  localparam int unsigned ZERO_LAT = 2;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_x, req_y;
  logic [31:0]           mul_x, mul_y, mul_z;
  logic                  resp_valid, resp_ready;
  logic [31:0]           resp_z;
  logic [ID_W-1:0]       resp_id;
  logic [CNT_W-1:0]      op_count;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_id(resp_id), .op_count(op_count)
  );

  // Truncating fp32 multiply for normal operands; zero exponent gives +0.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return '0;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (m[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, m[46:24]};
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  assign mul_z = fmul(mul_x, mul_y);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     z;
  } exp_t;

  exp_t            sb[$];
  logic [31:0]     exp_z [NUM_REQ];
  int unsigned     grant_log[$];
  int unsigned     grant_cyc[$];
  int unsigned     cyc = 0;
  logic [ID_W-1:0] rr_model = '0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] exp_grant(input logic [NUM_REQ-1:0] v,
                                                   input logic [ID_W-1:0] p);
    for (int unsigned k = 0; k < NUM_REQ; k++)
      if (v[(32'(p) + k) % NUM_REQ]) return NUM_REQ'(1) << ((32'(p) + k) % NUM_REQ);
    return '0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, inputs change only after rising edges.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      rr_model = '0;
      exp_cnt  = '0;
    end else begin
      if (resp_valid && !resp_ready) chk("hold_no_ready", 64'(req_ready), 64'(0));
      if (resp_valid && resp_ready) begin
        chk("op_count", 64'(op_count), 64'(exp_cnt));
        exp_cnt = exp_cnt + CNT_W'(1);
        if (sb.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'(0));
        else begin
          e = sb.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_z", 64'(resp_z), 64'(e.z));
        end
      end
      if (req_ready != '0) begin
        chk("grant", 64'(req_ready), 64'(exp_grant(req_valid, rr_model)));
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) begin
            e.id = ID_W'(i);
            e.z  = exp_z[i];
            sb.push_back(e);
            grant_log.push_back(i);
            grant_cyc.push_back(cyc);
            rr_model = (i == NUM_REQ - 1) ? '0 : ID_W'(i + 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int unsigned id, input string tag);
    for (int unsigned t = 0; t < 20; t++) begin
      @(negedge clk);
      #1;
      if (req_ready[id]) return;
    end
    chk({tag, "_grant_timeout"}, 64'(req_ready[id]), 64'(1));
  endtask

  task automatic wait_drain(input string tag);
    for (int unsigned t = 0; t < 20; t++) begin
      @(negedge clk);
      #1;
      if (!resp_valid && sb.size() == 0) break;
    end
    chk({tag, "_drain"}, 64'(sb.size()), 64'(0));
  endtask

  // One request from requester id; checks handshake and accept-to-valid latency.
  task automatic do_single(input int unsigned id, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input int unsigned lat, input string tag);
    int unsigned lat_obs;
    req_x[32*id +: 32] = x;
    req_y[32*id +: 32] = y;
    exp_z[id]          = z;
    req_valid          = NUM_REQ'(1) << id;
    wait_grant(id, tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(NUM_REQ'(1) << id));
    tick();
    req_valid = '0;
    lat_obs = 0;
    for (int unsigned t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat_obs = t;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat_obs), 64'(lat));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    req_x      = '0;
    req_y      = '0;
    resp_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) exp_z[i] = '0;

    // Reset with all requests pending
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_op_count", 64'(op_count), 64'(0));
    chk("rst_mul_x", 64'(mul_x), 64'(0));
    chk("rst_mul_y", 64'(mul_y), 64'(0));
    tick();
    req_valid  = '0;
    rst_n      = 1'b1;
    resp_ready = 1'b1;

    // Single op: 2.0 * 3.0 = 6.0
    tick();
    do_single(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 2, "single");
    @(negedge clk);
    chk("single_count", 64'(op_count), 64'(1));
    chk("single_idle", 64'(resp_valid), 64'(0));

    // Round robin from a fresh pointer: 1.5 * 1.5 = 2.25
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    grant_cyc.delete();
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_x[32*i +: 32] = 32'h3FC0_0000;
      req_y[32*i +: 32] = 32'h3FC0_0000;
      exp_z[i]          = 32'h4010_0000;
    end
    req_valid = '1;
    for (int unsigned t = 0; t < 40; t++) begin
      @(negedge clk);
      #1;
      if (grant_log.size() >= 5) break;
    end
    tick();
    req_valid = '0;
    chk("rr_count", 64'(grant_log.size()), 64'(5));
    for (int unsigned i = 0; i < 5 && i < grant_log.size(); i++)
      chk("rr_order", 64'(grant_log[i]), 64'(i % NUM_REQ));
    for (int unsigned i = 1; i < 5 && i < grant_cyc.size(); i++)
      chk("rr_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(2));
    wait_drain("rr");

    // Backpressure: 2.0 * 2.0 = 4.0 held; 1.5 * 2.0 = 3.0 waits behind it
    tick();
    resp_ready         = 1'b0;
    req_x[32*3 +: 32]  = 32'h4000_0000;
    req_y[32*3 +: 32]  = 32'h4000_0000;
    exp_z[3]           = 32'h4080_0000;
    req_valid          = 4'b1000;
    wait_grant(3, "bp");
    tick();
    req_x[31:0] = 32'h3FC0_0000;
    req_y[31:0] = 32'h4000_0000;
    exp_z[0]    = 32'h4040_0000;
    req_valid   = 4'b0001;
    for (int unsigned t = 0; t < 6; t++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    for (int unsigned t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'(1));
      chk("bp_z", 64'(resp_z), 64'(32'h4080_0000));
      chk("bp_id", 64'(resp_id), 64'(3));
      chk("bp_ready", 64'(req_ready), 64'(0));
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    wait_drain("bp");

    // Zero operand: 0 * 3.0
    tick();
    do_single(1, 32'h0000_0000, 32'h4040_0000, 32'h0000_0000, ZERO_LAT, "zero");

    // Reset while the operation sits in CALC
    tick();
    req_x[32*2 +: 32] = 32'h4000_0000;
    req_y[32*2 +: 32] = 32'h4040_0000;
    exp_z[2]          = 32'h40C0_0000;
    req_valid         = 4'b0100;
    wait_grant(2, "mid");
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_count", 64'(op_count), 64'(0));
    chk("mid_mul_x", 64'(mul_x), 64'(0));
    for (int unsigned t = 0; t < 3; t++) begin
      chk("mid_no_resp", 64'(resp_valid), 64'(0));
      @(negedge clk);
    end
    tick();
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_x[32*i +: 32] = 32'h3FC0_0000;
      req_y[32*i +: 32] = 32'h3FC0_0000;
      exp_z[i]          = 32'h4010_0000;
    end
    req_valid = '1;
    @(negedge clk);
    chk("post_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    wait_drain("post");
    @(negedge clk);
    chk("post_count", 64'(op_count), 64'(1));

    chk("sb_left", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
